// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: hazard controls, EX redirect, instruction memory port and IF/ID outputs.
interface fetch_stage_if;
  logic        i_stallF;
  logic        i_stallD;
  logic        i_flushD;
  logic        i_pc_sel_ex;
  logic [31:0] i_pc_target;
  logic [31:0] o_imem_addr;
  logic        o_imem_en;
  logic [31:0] i_imem_rdata;
  logic [6:0]  o_opcodeIF;
  logic [31:0] o_pcD;
  logic [31:0] o_instrD;
  logic        o_validD;

  modport master (
    input  i_stallF, i_stallD, i_flushD, i_pc_sel_ex, i_pc_target, i_imem_rdata,
    output o_imem_addr, o_imem_en, o_opcodeIF, o_pcD, o_instrD, o_validD
  );

  modport slave (
    output i_stallF, i_stallD, i_flushD, i_pc_sel_ex, i_pc_target, i_imem_rdata,
    input  o_imem_addr, o_imem_en, o_opcodeIF, o_pcD, o_instrD, o_validD
  );
endinterface

// File: rtl/fetch_stage.sv
// IF stage + IF/ID register: owns the PC, fetches from a 1-cycle synchronous imem.
// Latency: reset release to first valid D = 2 edges; redirect to target in D = 3 edges.
// Backpressure: stallF freezes PC and parks the IF instruction in a hold buffer; stallD freezes IF/ID.
module fetch_stage #(
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic           i_clk,
  input logic           i_reset,
  fetch_stage_if.master bus
);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_REDIR = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        vld;
  } ifid_t;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [31:0] pc_f;
  logic [31:0] pc_if;
  logic [31:0] hold_pc;
  logic [31:0] hold_instr;
  logic        hold_vld;
  ifid_t       ifid;

  logic        imem_en;
  logic [31:0] target;
  logic        slot_vld;
  logic [31:0] slot_pc;
  logic [31:0] slot_instr;

  assign target     = bus.i_pc_target & 32'hFFFF_FFFC;
  assign imem_en    = !i_reset && !(bus.i_stallF && !bus.i_pc_sel_ex);
  assign slot_vld   = (state == S_RUN);
  assign slot_instr = hold_vld ? hold_instr : bus.i_imem_rdata;
  assign slot_pc    = hold_vld ? hold_pc : pc_if;

  // A BOOT/REDIR cycle only retires once its address has actually been strobed.
  always_comb begin
    state_nxt = state;
    if (bus.i_pc_sel_ex) begin
      state_nxt = S_REDIR;
    end else if (imem_en) begin
      state_nxt = S_RUN;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= S_BOOT;
      pc_f       <= PC_RESET;
      pc_if      <= PC_RESET;
      hold_vld   <= 1'b0;
      hold_pc    <= 32'h0;
      hold_instr <= 32'h0;
    end else begin
      state <= state_nxt;
      if (bus.i_pc_sel_ex) begin
        pc_f     <= target;
        hold_vld <= 1'b0;
      end else if (!bus.i_stallF) begin
        pc_f     <= pc_f + 32'd4;
        hold_vld <= 1'b0;
      end else if (slot_vld && !hold_vld) begin
        hold_vld   <= 1'b1;
        hold_instr <= bus.i_imem_rdata;
        hold_pc    <= pc_if;
      end
      if (imem_en) begin
        pc_if <= pc_f;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ifid <= '{pc: 32'h0, instr: NOP_INSTR, vld: 1'b0};
    end else if (bus.i_flushD || bus.i_pc_sel_ex) begin
      ifid.vld   <= 1'b0;
      ifid.instr <= NOP_INSTR;
    end else if (bus.i_stallD) begin
      ifid <= ifid;
    end else if (bus.i_stallF) begin
      ifid.vld   <= 1'b0;
      ifid.instr <= NOP_INSTR;
    end else begin
      ifid <= '{pc: slot_pc, instr: (slot_vld ? slot_instr : NOP_INSTR), vld: slot_vld};
    end
  end

  // Feeds the hazard unit's stallF in the same cycle; must stay free of other comb inputs.
  assign bus.o_opcodeIF  = slot_vld ? slot_instr[6:0] : 7'h13;
  assign bus.o_imem_addr = pc_f;
  assign bus.o_imem_en   = imem_en;
  assign bus.o_pcD       = ifid.pc;
  assign bus.o_instrD    = ifid.instr;
  assign bus.o_validD    = ifid.vld;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a D-stage scoreboard.
module tb_fetch_stage;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] BEQ_ADDR = 32'h0000_0014;

  logic clk = 1'b0;
  logic rst;
  logic rst2;
  int   vectors = 0;
  int   miscompares = 0;

  fetch_stage_if bus();
  fetch_stage_if bus2();

  fetch_stage #(.PC_RESET(32'h0000_0000), .NOP_INSTR(NOP)) dut (.i_clk(clk), .i_reset(rst), .bus(bus));
  fetch_stage #(.PC_RESET(32'hFFFF_FFF8), .NOP_INSTR(NOP)) dut2 (.i_clk(clk), .i_reset(rst2), .bus(bus2));

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a == BEQ_ADDR) return 32'h0000_0063;
    return {a[26:2], 7'h33};
  endfunction

  // Read data is garbage whenever the strobe is low, so a held IF slot must come from the hold buffer.
  always @(posedge clk) bus.i_imem_rdata <= bus.o_imem_en ? mem_rd(bus.o_imem_addr) : 32'hDEAD_BEEF;
  always @(posedge clk) bus2.i_imem_rdata <= mem_rd(bus2.o_imem_addr);

  logic [31:0] sb_q[$];
  bit          sb_on = 1'b0;
  logic        loaded_edge = 1'b0;
  logic [31:0] sb_exp;

  always @(posedge clk)
    loaded_edge <= !rst && !bus.i_flushD && !bus.i_pc_sel_ex && !bus.i_stallD && !bus.i_stallF;

  always @(negedge clk) begin
    if (sb_on && loaded_edge && bus.o_validD) begin
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected got pcD=%h instrD=%h, required no new D entry", bus.o_pcD, bus.o_instrD);
      end else begin
        sb_exp = sb_q.pop_front();
        if (bus.o_pcD !== sb_exp || bus.o_instrD !== mem_rd(sb_exp)) begin
          miscompares++;
          $display("FAIL sb_entry got pcD=%h instrD=%h, required pcD=%h instrD=%h",
                   bus.o_pcD, bus.o_instrD, sb_exp, mem_rd(sb_exp));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    #1;
    vectors++; if (bus.o_imem_en !== 1'b0) begin miscompares++; $display("FAIL rst_en got=%b exp=0", bus.o_imem_en); end
    vectors++; if (bus.o_imem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_addr got=%h exp=0", bus.o_imem_addr); end
    vectors++; if (bus.o_validD !== 1'b0) begin miscompares++; $display("FAIL rst_validD got=%b exp=0", bus.o_validD); end
    vectors++; if (bus.o_instrD !== NOP) begin miscompares++; $display("FAIL rst_instrD got=%h exp=%h", bus.o_instrD, NOP); end
    vectors++; if (bus.o_pcD !== 32'h0) begin miscompares++; $display("FAIL rst_pcD got=%h exp=0", bus.o_pcD); end
    vectors++; if (bus.o_opcodeIF !== 7'h13) begin miscompares++; $display("FAIL rst_opcode got=%h exp=13", bus.o_opcodeIF); end
  endtask

  task automatic test_free_run();
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    vectors++; if (bus.o_imem_en !== 1'b1) begin miscompares++; $display("FAIL boot_en got=%b exp=1", bus.o_imem_en); end
    vectors++; if (bus.o_opcodeIF !== 7'h13) begin miscompares++; $display("FAIL boot_opcode got=%h exp=13", bus.o_opcodeIF); end
    sb_on = 1'b1;
    for (int i = 0; i < 5; i++) sb_q.push_back(32'(4 * i));
    for (int i = 1; i <= 6; i++) begin
      step();
      vectors++; if (bus.o_imem_addr !== 32'(4 * i)) begin miscompares++; $display("FAIL run_addr%0d got=%h exp=%h", i, bus.o_imem_addr, 32'(4 * i)); end
      if (i == 1) begin
        vectors++; if (bus.o_validD !== 1'b0) begin miscompares++; $display("FAIL run_valid_e1 got=%b exp=0", bus.o_validD); end
        vectors++; if (bus.o_opcodeIF !== 7'h33) begin miscompares++; $display("FAIL run_opcode got=%h exp=33", bus.o_opcodeIF); end
      end
      if (i == 2) begin
        vectors++; if (bus.o_validD !== 1'b1) begin miscompares++; $display("FAIL run_valid_e2 got=%b exp=1", bus.o_validD); end
      end
    end
  endtask

  task automatic test_stall_if();
    sb_q.push_back(BEQ_ADDR);
    bus.i_stallF = 1'b1;
    #1;
    vectors++; if (bus.o_imem_en !== 1'b0) begin miscompares++; $display("FAIL stall_en got=%b exp=0", bus.o_imem_en); end
    vectors++; if (bus.o_opcodeIF !== 7'h63) begin miscompares++; $display("FAIL stall_opcode0 got=%h exp=63", bus.o_opcodeIF); end
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++; if (bus.o_imem_addr !== 32'h18) begin miscompares++; $display("FAIL stall_addr%0d got=%h exp=18", k, bus.o_imem_addr); end
      vectors++; if (bus.o_opcodeIF !== 7'h63) begin miscompares++; $display("FAIL stall_opcode%0d got=%h exp=63", k, bus.o_opcodeIF); end
      vectors++; if (bus.o_validD !== 1'b0 || bus.o_instrD !== NOP) begin miscompares++; $display("FAIL stall_bubble%0d got v=%b i=%h exp v=0 i=%h", k, bus.o_validD, bus.o_instrD, NOP); end
    end
    bus.i_stallF = 1'b0;
    step();
    vectors++; if (bus.o_pcD !== BEQ_ADDR || bus.o_instrD !== 32'h63 || bus.o_validD !== 1'b1) begin miscompares++; $display("FAIL stall_release got pc=%h i=%h v=%b exp pc=%h i=63 v=1", bus.o_pcD, bus.o_instrD, bus.o_validD, BEQ_ADDR); end
    vectors++; if (bus.o_imem_addr !== 32'h1C) begin miscompares++; $display("FAIL stall_release_addr got=%h exp=1c", bus.o_imem_addr); end
  endtask

  task automatic test_redirect();
    sb_q.push_back(32'h100);
    bus.i_stallF = 1'b1;
    bus.i_pc_sel_ex = 1'b1;
    bus.i_pc_target = 32'h0000_0103;
    #1;
    vectors++; if (bus.o_imem_en !== 1'b1) begin miscompares++; $display("FAIL redir_en got=%b exp=1", bus.o_imem_en); end
    step();
    bus.i_stallF = 1'b0;
    bus.i_pc_sel_ex = 1'b0;
    bus.i_pc_target = 32'h0;
    #1;
    vectors++; if (bus.o_imem_addr !== 32'h100) begin miscompares++; $display("FAIL redir_addr got=%h exp=100", bus.o_imem_addr); end
    vectors++; if (bus.o_opcodeIF !== 7'h13) begin miscompares++; $display("FAIL redir_opcode got=%h exp=13", bus.o_opcodeIF); end
    vectors++; if (bus.o_validD !== 1'b0) begin miscompares++; $display("FAIL redir_flush got=%b exp=0", bus.o_validD); end
    step();
    vectors++; if (bus.o_validD !== 1'b0) begin miscompares++; $display("FAIL redir_drop got=%b exp=0", bus.o_validD); end
    step();
    vectors++; if (bus.o_validD !== 1'b1 || bus.o_pcD !== 32'h100) begin miscompares++; $display("FAIL redir_land got v=%b pc=%h exp v=1 pc=100", bus.o_validD, bus.o_pcD); end
  endtask

  task automatic test_load_use();
    sb_q.push_back(32'h104);
    sb_q.push_back(32'h108);
    sb_q.push_back(32'h10C);
    bus.i_stallF = 1'b1;
    bus.i_stallD = 1'b1;
    #1;
    vectors++; if (bus.o_imem_en !== 1'b0) begin miscompares++; $display("FAIL lu_en got=%b exp=0", bus.o_imem_en); end
    for (int k = 0; k < 2; k++) begin
      step();
      vectors++; if (bus.o_pcD !== 32'h100 || bus.o_validD !== 1'b1 || bus.o_instrD !== mem_rd(32'h100)) begin miscompares++; $display("FAIL lu_hold%0d got pc=%h v=%b i=%h exp pc=100 v=1 i=%h", k, bus.o_pcD, bus.o_validD, bus.o_instrD, mem_rd(32'h100)); end
      vectors++; if (bus.o_imem_addr !== 32'h108) begin miscompares++; $display("FAIL lu_addr%0d got=%h exp=108", k, bus.o_imem_addr); end
    end
    bus.i_stallF = 1'b0;
    bus.i_stallD = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      vectors++; if (bus.o_pcD !== 32'(32'h100 + 4 * k)) begin miscompares++; $display("FAIL lu_after%0d got=%h exp=%h", k, bus.o_pcD, 32'(32'h100 + 4 * k)); end
    end
    @(negedge clk);
    #1;
    vectors++; if (sb_q.size() != 0) begin miscompares++; $display("FAIL lu_sb_drain got=%0d exp=0 pending", sb_q.size()); end
    sb_on = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    step();
    bus.i_stallF = 1'b1;
    step();
    vectors++; if (bus.o_imem_addr !== 32'h118) begin miscompares++; $display("FAIL rms_addr got=%h exp=118", bus.o_imem_addr); end
    rst = 1'b1;
    #1;
    vectors++; if (bus.o_imem_en !== 1'b0) begin miscompares++; $display("FAIL rms_en got=%b exp=0", bus.o_imem_en); end
    step();
    vectors++; if (bus.o_imem_addr !== 32'h0) begin miscompares++; $display("FAIL rms_pc got=%h exp=0", bus.o_imem_addr); end
    vectors++; if (bus.o_validD !== 1'b0 || bus.o_instrD !== NOP || bus.o_pcD !== 32'h0) begin miscompares++; $display("FAIL rms_d got v=%b i=%h pc=%h exp v=0 i=%h pc=0", bus.o_validD, bus.o_instrD, bus.o_pcD, NOP); end
    vectors++; if (bus.o_opcodeIF !== 7'h13) begin miscompares++; $display("FAIL rms_opcode got=%h exp=13", bus.o_opcodeIF); end
    rst = 1'b0;
    bus.i_stallF = 1'b0;
    sb_on = 1'b1;
    sb_q.push_back(32'h0);
    #1;
    vectors++; if (bus.o_imem_en !== 1'b1) begin miscompares++; $display("FAIL rms_boot_en got=%b exp=1", bus.o_imem_en); end
    step();
    vectors++; if (bus.o_imem_addr !== 32'h4 || bus.o_validD !== 1'b0) begin miscompares++; $display("FAIL rms_e1 got a=%h v=%b exp a=4 v=0", bus.o_imem_addr, bus.o_validD); end
    step();
    vectors++; if (bus.o_validD !== 1'b1 || bus.o_pcD !== 32'h0) begin miscompares++; $display("FAIL rms_e2 got v=%b pc=%h exp v=1 pc=0", bus.o_validD, bus.o_pcD); end
    @(negedge clk);
    #1;
    vectors++; if (sb_q.size() != 0) begin miscompares++; $display("FAIL rms_sb_drain got=%0d exp=0 pending", sb_q.size()); end
    sb_on = 1'b0;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_addr [6];
    exp_addr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8, 32'hC};
    @(posedge clk);
    #1 rst2 = 1'b0;
    #1;
    vectors++; if (bus2.o_imem_addr !== exp_addr[0]) begin miscompares++; $display("FAIL wrap_addr0 got=%h exp=%h", bus2.o_imem_addr, exp_addr[0]); end
    for (int i = 1; i < 6; i++) begin
      step();
      vectors++; if (bus2.o_imem_addr !== exp_addr[i]) begin miscompares++; $display("FAIL wrap_addr%0d got=%h exp=%h", i, bus2.o_imem_addr, exp_addr[i]); end
      if (i >= 2) begin
        vectors++; if (bus2.o_validD !== 1'b1 || bus2.o_pcD !== exp_addr[i - 2]) begin miscompares++; $display("FAIL wrap_pcD%0d got v=%b pc=%h exp v=1 pc=%h", i, bus2.o_validD, bus2.o_pcD, exp_addr[i - 2]); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst  = 1'b1;
    rst2 = 1'b1;
    bus.i_stallF     = 1'b0;
    bus.i_stallD     = 1'b0;
    bus.i_flushD     = 1'b0;
    bus.i_pc_sel_ex  = 1'b0;
    bus.i_pc_target  = 32'h0;
    bus2.i_stallF    = 1'b0;
    bus2.i_stallD    = 1'b0;
    bus2.i_flushD    = 1'b0;
    bus2.i_pc_sel_ex = 1'b0;
    bus2.i_pc_target = 32'h0;
    test_reset();
    test_free_run();
    test_stall_if();
    test_redirect();
    test_load_use();
    test_reset_mid_stall();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
